// File: rtl/latent_noise_generator.sv
// latent_noise_generator: LFSR-driven approximately Gaussian Q8.8 latent vector source
module latent_noise_generator #(
  parameter int          NUM_SAMPLES = 64,
  parameter int          SUM_TERMS   = 4,
  parameter logic [31:0] SEED        = 32'hACE12468,
  parameter logic [31:0] LFSR_MASK   = 32'h80200003,
  parameter int          SCALE_SHIFT = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      seed_load,
  input  logic [31:0]               seed_in,
  output logic [16*NUM_SAMPLES-1:0] flat_noise,
  output logic                      busy,
  output logic                      valid,
  output logic                      done
);
  localparam int AW     = $clog2(SUM_TERMS * 4096) + 1;
  localparam int IW     = NUM_SAMPLES > 1 ? $clog2(NUM_SAMPLES) : 1;
  localparam int TW     = $clog2(SUM_TERMS);
  localparam int CENTRE = SUM_TERMS * 4095 / 2;
  typedef enum logic {IDLE, RUN} state_t;
  state_t             state;
  logic [31:0]        lfsr, nxt;
  logic [AW-1:0]      acc, acc_sum;
  logic [IW-1:0]      sample_idx;
  logic [TW-1:0]      term_idx;
  logic signed [31:0] centred;
  logic [15:0]        sample;
  always_comb begin
    nxt     = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_MASK : 32'd0);
    acc_sum = acc + AW'(nxt[11:0]);
    centred = $signed(32'(acc_sum)) - CENTRE;
    sample  = 16'(centred >>> SCALE_SHIFT);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lfsr       <= SEED;
      flat_noise <= '0;
      busy       <= 1'b0;
      valid      <= 1'b0;
      done       <= 1'b0;
      acc        <= '0;
      sample_idx <= '0;
      term_idx   <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (seed_load) lfsr <= (seed_in == 32'd0) ? SEED : seed_in;
        if (start) begin
          state      <= RUN;
          busy       <= 1'b1;
          valid      <= 1'b0;
          acc        <= '0;
          sample_idx <= '0;
          term_idx   <= '0;
        end
      end else begin
        lfsr <= nxt;
        if (term_idx != TW'(SUM_TERMS - 1)) begin
          acc      <= acc_sum;
          term_idx <= term_idx + 1'b1;
        end else begin
          flat_noise[{sample_idx, 4'b0000} +: 16] <= sample;
          acc      <= '0;
          term_idx <= '0;
          if (sample_idx == IW'(NUM_SAMPLES - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            valid <= 1'b1;
            done  <= 1'b1;
          end else begin
            sample_idx <= sample_idx + 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_latent_noise_generator.sv
// tb_latent_noise_generator: directed runs scored against a golden LFSR/sum model
module tb_latent_noise_generator;
  localparam logic [31:0] SEED = 32'hACE12468;
  localparam logic [31:0] MASK = 32'h80200003;
  logic          clk = 1'b0, rst = 1'b1, start = 1'b0, seed_load = 1'b0;
  logic [31:0]   seed_in = '0;
  logic [1023:0] flat_noise;
  logic          busy, valid, done;
  int            total = 0, bad = 0;
  logic [31:0]   m_lfsr = SEED;
  logic [15:0]   sbq[$];
  logic [1023:0] exp_vec, first_vec, prev_vec;

  latent_noise_generator dut (
    .clk(clk), .rst(rst), .start(start), .seed_load(seed_load), .seed_in(seed_in),
    .flat_noise(flat_noise), .busy(busy), .valid(valid), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] step(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? MASK : 32'd0);
  endfunction

  task automatic model_run;
    for (int s = 0; s < 64; s++) begin
      int a, v;
      a = 0;
      for (int t = 0; t < 4; t++) begin
        m_lfsr = step(m_lfsr);
        a += int'(m_lfsr[11:0]);
      end
      v = (a - 8190) >>> 3;
      sbq.push_back(16'(v));
    end
  endtask

  task automatic load_seed(input logic [31:0] s);
    @(negedge clk); seed_load = 1'b1; seed_in = s;
    @(negedge clk); seed_load = 1'b0;
    m_lfsr = (s == 32'd0) ? SEED : s;
  endtask

  // mode 0: plain run, 1: start/seed_load pokes mid-run, 2: reset at cycle 150
  task automatic run(input string tag, input int mode);
    int cyc;
    logic [15:0] e;
    cyc = 0;
    model_run();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk({tag, " busy_rise"}, busy, 1);
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (mode == 1) begin
        if (cyc == 100) start = 1'b1;
        else if (cyc == 101) begin start = 1'b0; seed_load = 1'b1; seed_in = 32'hDEADBEEF; end
        else if (cyc == 102) seed_load = 1'b0;
      end
      if (mode == 2 && cyc == 150) begin
        rst = 1'b1;
        @(negedge clk); chk({tag, " no_done_in_rst"}, done, 0);
        @(negedge clk); rst = 1'b0;
        chk({tag, " busy_after_rst"}, busy, 0);
        chk({tag, " valid_after_rst"}, valid, 0);
        @(negedge clk); chk({tag, " no_done_after_rst"}, done, 0);
        sbq.delete();
        m_lfsr = SEED;
        return;
      end
    end
    chk({tag, " latency"}, cyc, 256);
    chk({tag, " done"}, done, 1);
    chk({tag, " valid"}, valid, 1);
    chk({tag, " busy_fall"}, busy, 0);
    for (int i = 0; i < 64; i++) exp_vec[i*16 +: 16] = sbq.pop_front();
    for (int i = 0; i < 64; i++) begin
      e = flat_noise[i*16 +: 16];
      chk($sformatf("%s elem%0d", tag, i), e, exp_vec[i*16 +: 16]);
      chk($sformatf("%s range%0d", tag, i), ($signed(e) >= -16'sd1024 && $signed(e) <= 16'sd1023), 1);
    end
    @(negedge clk);
    chk({tag, " done_one_cycle"}, done, 0);
    chk({tag, " valid_hold"}, valid, 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst flat_noise", flat_noise, 0);
    chk("rst busy", busy, 0);
    chk("rst valid", valid, 0);
    chk("rst done", done, 0);
    rst = 1'b0;
    run("default", 0);
    first_vec = exp_vec;
    load_seed(32'h00000001);
    run("nominal", 0);
    prev_vec = exp_vec;
    load_seed(32'h00000001);
    run("repeat", 0);
    chk("repro", flat_noise, prev_vec);
    run("no_reload", 0);
    chk("differs", flat_noise !== prev_vec, 1);
    load_seed(32'h00000000);
    run("zero_seed", 0);
    chk("zero_eq_default", flat_noise, first_vec);
    run("protocol", 1);
    run("reset_mid", 2);
    run("post_reset", 0);
    chk("post_reset_eq_default", flat_noise, first_vec);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
